dma_chn_arb: RTL and testbench

- Channel scheduler for the DMA controller. It sits between the per-channel trigger latches and the single shared transfer engine.
- Each cycle it samples the latched triggers of enabled channels and picks one winner: highest programmed priority first, then round-robin among equal priorities.
- It hands the winner to the engine with a valid/ack handshake, pulses that channel's trigger-clear on acceptance, and holds off further grants until the engine reports done.

---
 rtl/dma_chn_arb.sv | 154 +++++++++++++++
 tb/tb_dma_chn_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_chn_arb.sv
// DMA channel scheduler: fixed priority with round-robin tie-break, granting one channel
// at a time to the shared transfer engine through a valid/ack/done handshake.
module dma_chn_arb #(
   parameter int CHN_NUM   = 8,
   parameter int CHN_IDX_W = 3
) (
   input  logic                   hclk,
   input  logic                   hrst_n,
   input  logic [CHN_NUM-1:0]     chntrg_latch,
   input  logic [CHN_NUM-1:0]     chn_en,
   input  logic [2*CHN_NUM-1:0]   chn_pri,
   input  logic                   eng_ack,
   input  logic                   eng_done,
   output logic                   arb_grant_vld,
   output logic [CHN_IDX_W-1:0]   arb_grant_chn,
   output logic [CHN_NUM-1:0]     arb_grant_oh,
   output logic [CHN_NUM-1:0]     chn_trgclr,
   output logic                   arb_busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARB   = 2'd1;
   localparam logic [1:0] GRANT = 2'd2;
   localparam logic [1:0] BUSY  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [CHN_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic                 vld_q, vld_d;
   logic [CHN_IDX_W-1:0] chn_q, chn_d;
   logic [CHN_NUM-1:0]   oh_q, oh_d;
   logic [CHN_NUM-1:0]   trgclr_q, trgclr_d;

   logic [CHN_NUM-1:0]   req;
   logic [1:0]           pri_a [CHN_NUM];
   logic [1:0]           maxp;
   logic [CHN_NUM-1:0]   cand;
   logic                 found_hi;
   logic [CHN_IDX_W-1:0] win_hi, win_lo, win_idx;
   logic [CHN_NUM-1:0]   win_oh;
   logic                 win_en;
   logic [CHN_IDX_W-1:0] next_ptr;

   assign req = chntrg_latch & chn_en;

   always_comb begin
      for (int i = 0; i < CHN_NUM; i++) begin
         pri_a[i] = chn_pri[2*i +: 2];
      end
   end

   always_comb begin
      maxp = 2'd0;
      for (int i = 0; i < CHN_NUM; i++) begin
         if (req[i] && (pri_a[i] > maxp)) maxp = pri_a[i];
      end
   end

   always_comb begin
      for (int i = 0; i < CHN_NUM; i++) begin
         cand[i] = req[i] && (pri_a[i] == maxp);
      end
   end

   // Downward scan leaves the lowest candidate at/above rr_ptr in win_hi and the lowest
   // candidate overall in win_lo; the latter is the wrap-around choice.
   always_comb begin
      found_hi = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = CHN_NUM - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win_lo = CHN_IDX_W'(i);
            if (CHN_IDX_W'(i) >= rr_ptr_q) begin
               win_hi   = CHN_IDX_W'(i);
               found_hi = 1'b1;
            end
         end
      end
      win_idx = found_hi ? win_hi : win_lo;
   end

   assign win_oh   = {{(CHN_NUM-1){1'b0}}, 1'b1} << win_idx;
   assign win_en   = |(chn_en & oh_q);
   assign next_ptr = (chn_q == CHN_IDX_W'(CHN_NUM - 1)) ? '0 : chn_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      vld_d    = vld_q;
      chn_d    = chn_q;
      oh_d     = oh_q;
      trgclr_d = '0;
      case (state_q)
         IDLE: begin
            if (|req) state_d = ARB;
         end
         ARB: begin
            if (|req) begin
               chn_d   = win_idx;
               oh_d    = win_oh;
               vld_d   = 1'b1;
               state_d = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            // Disable wins over a simultaneous ack: the grant is cancelled without a clear.
            if (!win_en) begin
               vld_d   = 1'b0;
               oh_d    = '0;
               state_d = IDLE;
            end else if (eng_ack) begin
               trgclr_d = oh_q;
               vld_d    = 1'b0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (eng_done) begin
               rr_ptr_d = next_ptr;
               oh_d     = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         vld_q    <= 1'b0;
         chn_q    <= '0;
         oh_q     <= '0;
         trgclr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         vld_q    <= vld_d;
         chn_q    <= chn_d;
         oh_q     <= oh_d;
         trgclr_q <= trgclr_d;
      end
   end

   assign arb_grant_vld = vld_q;
   assign arb_grant_chn = chn_q;
   assign arb_grant_oh  = oh_q;
   assign chn_trgclr    = trgclr_q;
   assign arb_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dma_chn_arb.sv
// Directed bench for dma_chn_arb; expected grant order is queued as stimulus is applied
// and checked against each grant the arbiter raises.
module tb_dma_chn_arb;

   logic        hclk;
   logic        hrst_n;
   logic [7:0]  chntrg_latch;
   logic [7:0]  chn_en;
   logic [15:0] chn_pri;
   logic        eng_ack;
   logic        eng_done;
   logic        arb_grant_vld;
   logic [2:0]  arb_grant_chn;
   logic [7:0]  arb_grant_oh;
   logic [7:0]  chn_trgclr;
   logic        arb_busy;

   int n_assert = 0;
   int n_fail   = 0;
   int sb[$];
   int cur_chn  = 0;

   dma_chn_arb #(.CHN_NUM(8), .CHN_IDX_W(3)) dut (
      .hclk          (hclk),
      .hrst_n        (hrst_n),
      .chntrg_latch  (chntrg_latch),
      .chn_en        (chn_en),
      .chn_pri       (chn_pri),
      .eng_ack       (eng_ack),
      .eng_done      (eng_done),
      .arb_grant_vld (arb_grant_vld),
      .arb_grant_chn (arb_grant_chn),
      .arb_grant_oh  (arb_grant_oh),
      .chn_trgclr    (chn_trgclr),
      .arb_busy      (arb_busy)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a grant, then compare it with the next queued expectation.
   task automatic wait_grant(input string tag);
      int k = 0;
      int exp;
      while (!arb_grant_vld && k < 20) begin
         tick();
         k++;
      end
      check({tag, "_vld"}, 32'(arb_grant_vld), 32'd1);
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s_sb: observed grant 0x%0h expected no grant", tag, arb_grant_chn);
         exp = 0;
      end else begin
         exp = sb.pop_front();
      end
      check({tag, "_chn"}, 32'(arb_grant_chn), 32'(exp));
      check({tag, "_oh"}, 32'(arb_grant_oh), 32'd1 << exp);
      cur_chn = exp;
   endtask

   task automatic finish_grant(input string tag, input bit retrig);
      eng_ack = 1'b1;
      tick();
      eng_ack = 1'b0;
      check({tag, "_trgclr"}, 32'(chn_trgclr), 32'd1 << cur_chn);
      check({tag, "_vld_drop"}, 32'(arb_grant_vld), 32'd0);
      if (!retrig) chntrg_latch[cur_chn] = 1'b0;
      tick();
      check({tag, "_trgclr_end"}, 32'(chn_trgclr), 32'd0);
      check({tag, "_busy"}, 32'(arb_busy), 32'd1);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check({tag, "_idle"}, 32'(arb_busy), 32'd0);
      check({tag, "_oh_clr"}, 32'(arb_grant_oh), 32'd0);
   endtask

   initial begin
      hrst_n       = 1'b0;
      chntrg_latch = 8'h00;
      chn_en       = 8'h00;
      chn_pri      = 16'h0000;
      eng_ack      = 1'b0;
      eng_done     = 1'b0;
      repeat (2) @(posedge hclk);
      #1;
      check("rst_vld", 32'(arb_grant_vld), 32'd0);
      check("rst_chn", 32'(arb_grant_chn), 32'd0);
      check("rst_oh", 32'(arb_grant_oh), 32'd0);
      check("rst_trgclr", 32'(chn_trgclr), 32'd0);
      check("rst_busy", 32'(arb_busy), 32'd0);
      hrst_n = 1'b1;
      tick();

      // Single request on channel 2 with exact latency.
      chn_en       = 8'hFF;
      chntrg_latch = 8'h04;
      sb.push_back(2);
      tick();
      check("single_arb_busy", 32'(arb_busy), 32'd1);
      check("single_arb_vld", 32'(arb_grant_vld), 32'd0);
      tick();
      check("single_vld_n2", 32'(arb_grant_vld), 32'd1);
      wait_grant("single");
      tick();
      check("single_hold_chn", 32'(arb_grant_chn), 32'd2);
      finish_grant("single", 1'b0);

      // rr_ptr is now 3: among equal channels 0 and 3, channel 3 goes first.
      chntrg_latch = 8'h09;
      sb.push_back(3);
      sb.push_back(0);
      wait_grant("rr3_a");
      finish_grant("rr3_a", 1'b0);
      wait_grant("rr3_b");
      finish_grant("rr3_b", 1'b0);

      // Priority: channel 7 at 3 beats channel 0 at 1.
      chn_pri      = 16'hC001;
      chntrg_latch = 8'h81;
      sb.push_back(7);
      sb.push_back(0);
      wait_grant("pri_a");
      finish_grant("pri_a", 1'b0);
      wait_grant("pri_b");
      finish_grant("pri_b", 1'b0);

      // Reset mid-BUSY with rr_ptr=1; afterwards scanning restarts from channel 0.
      chn_pri      = 16'hAAAA;
      chntrg_latch = 8'h04;
      sb.push_back(2);
      wait_grant("rstb");
      eng_ack = 1'b1;
      tick();
      eng_ack = 1'b0;
      chntrg_latch = 8'h00;
      tick();
      check("rstb_in_busy", 32'(arb_busy), 32'd1);
      hrst_n = 1'b0;
      #1;
      check("rstb_vld", 32'(arb_grant_vld), 32'd0);
      check("rstb_chn", 32'(arb_grant_chn), 32'd0);
      check("rstb_oh", 32'(arb_grant_oh), 32'd0);
      check("rstb_trgclr", 32'(chn_trgclr), 32'd0);
      check("rstb_busy", 32'(arb_busy), 32'd0);
      @(posedge hclk);
      #1;
      hrst_n       = 1'b1;
      chntrg_latch = 8'h81;
      sb.push_back(0);
      sb.push_back(7);
      wait_grant("post_rst_a");
      finish_grant("post_rst_a", 1'b0);
      wait_grant("post_rst_b");
      finish_grant("post_rst_b", 1'b0);

      // Round-robin over all channels at equal priority, triggers re-latched; rr_ptr is 0.
      chntrg_latch = 8'hFF;
      for (int i = 0; i < 9; i++) sb.push_back(i % 8);
      for (int i = 0; i < 9; i++) begin
         wait_grant("rr");
         finish_grant("rr", 1'b1);
      end
      chntrg_latch = 8'h00;
      tick();
      check("rr_sb_drained", 32'(sb.size()), 32'd0);

      // Cancel: disable channel 5 in the same cycle as ack; rr_ptr stays 1.
      chntrg_latch = 8'h20;
      sb.push_back(5);
      wait_grant("cancel");
      eng_ack = 1'b1;
      chn_en  = 8'hDF;
      tick();
      eng_ack = 1'b0;
      check("cancel_vld", 32'(arb_grant_vld), 32'd0);
      check("cancel_trgclr", 32'(chn_trgclr), 32'd0);
      check("cancel_busy", 32'(arb_busy), 32'd0);
      check("cancel_oh", 32'(arb_grant_oh), 32'd0);
      chn_en       = 8'hFF;
      chntrg_latch = 8'h21;
      tick();
      check("cancel_trgclr_later", 32'(chn_trgclr), 32'd0);
      sb.push_back(5);
      sb.push_back(0);
      wait_grant("cancel_ptr_a");
      finish_grant("cancel_ptr_a", 1'b0);
      wait_grant("cancel_ptr_b");
      finish_grant("cancel_ptr_b", 1'b0);

      // Withdrawn request: channel 4 disabled during ARB.
      chntrg_latch = 8'h10;
      tick();
      check("wd_arb_busy", 32'(arb_busy), 32'd1);
      chn_en = 8'hEF;
      tick();
      check("wd_idle", 32'(arb_busy), 32'd0);
      check("wd_vld", 32'(arb_grant_vld), 32'd0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("wd_stay_idle", 32'(arb_busy), 32'd0);
      check("wd_oh", 32'(arb_grant_oh), 32'd0);
      chn_en       = 8'hFF;
      chntrg_latch = 8'h00;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
